// File: rtl/smiley_collision_detector_pkg.sv
// Shared constants and types for the smiley collision detector.
// Edge-bit positions match the hitEdgeCode layout consumed by the ball-motion logic.
package smiley_collision_detector_pkg;

    localparam int SMILEY_WIDTH  = 32;
    localparam int SMILEY_HEIGHT = 32;
    localparam int EDGE_MARGIN   = 8;

    localparam int EDGE_LEFT   = 3;
    localparam int EDGE_TOP    = 2;
    localparam int EDGE_RIGHT  = 1;
    localparam int EDGE_BOTTOM = 0;

    // Index of each collision type inside the per-type vectors of the top.
    localparam int NUM_TYPES    = 5;
    localparam int COL_TOP      = 0;
    localparam int COL_LEFT     = 1;
    localparam int COL_RIGHT    = 2;
    localparam int COL_FLIPPER  = 3;
    localparam int COL_OBSTACLE = 4;

    typedef enum logic {
        LATCH_ARMED = 1'b0,
        LATCH_FIRED = 1'b1
    } latch_state_e;

endpackage

// File: rtl/smiley_collision_detector_pulse_latch.sv
// Once-per-frame ARMED/FIRED gate for one collision type.
// pulse is the firing strobe for the current pixel; the top registers it.
module collision_pulse_latch
    import smiley_collision_detector_pkg::*;
(
    input  logic clk,
    input  logic resetN,
    input  logic overlap,
    input  logic qualify,
    input  logic clear,
    input  logic block,
    output logic pulse
);

    latch_state_e state_q;
    logic         armed_eff;
    logic         fire;

    // A clear in the same cycle as an overlap counts as already re-armed.
    always_comb begin
        armed_eff = clear || (state_q == LATCH_ARMED);
        fire      = armed_eff && overlap && qualify && !block;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= LATCH_ARMED;
        end else if (fire) begin
            state_q <= LATCH_FIRED;
        end else if (clear) begin
            state_q <= LATCH_ARMED;
        end
    end

    assign pulse = fire;

endmodule

// File: rtl/smiley_collision_detector.sv
// Pixel-rate collision producer for the smiley ball: one registered pulse per
// collision type per frame, plus the touched-edge code and a saturating hit count.
module smiley_collision_detector
    import smiley_collision_detector_pkg::*;
#(
    parameter int OBJECT_WIDTH  = SMILEY_WIDTH,
    parameter int OBJECT_HEIGHT = SMILEY_HEIGHT,
    parameter int EDGE_MARGIN   = smiley_collision_detector_pkg::EDGE_MARGIN,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   startOfFrame,
    input  logic                   reset_level,
    input  logic                   pause,
    input  logic                   smileyDR,
    input  logic [10:0]            smileyOffsetX,
    input  logic [10:0]            smileyOffsetY,
    input  logic                   borderTopDR,
    input  logic                   borderLeftDR,
    input  logic                   borderRightDR,
    input  logic                   flipperDR,
    input  logic                   obstacleDR,
    output logic                   collisionSmileyBorderTop,
    output logic                   collisionSmileyBorderLeft,
    output logic                   collisionSmileyBorderRight,
    output logic                   collisionSmileyFlipper,
    output logic                   collisionSmileyObstacle,
    output logic [3:0]             hitEdgeCode,
    output logic [COUNT_WIDTH-1:0] obstacleHitCount
);

    localparam logic [10:0] LOW_LIMIT_X  = 11'(EDGE_MARGIN);
    localparam logic [10:0] HIGH_LIMIT_X = 11'(OBJECT_WIDTH - EDGE_MARGIN);
    localparam logic [10:0] LOW_LIMIT_Y  = 11'(EDGE_MARGIN);
    localparam logic [10:0] HIGH_LIMIT_Y = 11'(OBJECT_HEIGHT - EDGE_MARGIN);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    logic [NUM_TYPES-1:0]   overlap_vec;
    logic [NUM_TYPES-1:0]   qualify_vec;
    logic [NUM_TYPES-1:0]   fire_vec;
    logic [NUM_TYPES-1:0]   pulse_q;
    logic [3:0]             edge_code;
    logic [3:0]             edge_q;
    logic [3:0]             edge_d;
    logic [COUNT_WIDTH-1:0] count_q;
    logic [COUNT_WIDTH-1:0] count_d;
    logic                   clear;
    logic                   block;

    always_comb begin
        edge_code              = 4'b0000;
        edge_code[EDGE_LEFT]   = smileyOffsetX <  LOW_LIMIT_X;
        edge_code[EDGE_RIGHT]  = smileyOffsetX >= HIGH_LIMIT_X;
        edge_code[EDGE_TOP]    = smileyOffsetY <  LOW_LIMIT_Y;
        edge_code[EDGE_BOTTOM] = smileyOffsetY >= HIGH_LIMIT_Y;
    end

    always_comb begin
        overlap_vec               = '0;
        overlap_vec[COL_TOP]      = smileyDR && borderTopDR;
        overlap_vec[COL_LEFT]     = smileyDR && borderLeftDR;
        overlap_vec[COL_RIGHT]    = smileyDR && borderRightDR;
        overlap_vec[COL_FLIPPER]  = smileyDR && flipperDR;
        overlap_vec[COL_OBSTACLE] = smileyDR && obstacleDR;

        // Centre hits on an obstacle carry no bounce direction, so they are ignored.
        qualify_vec               = '1;
        qualify_vec[COL_OBSTACLE] = |edge_code;
    end

    // reset_level both re-arms and suppresses firing in its own cycle.
    assign clear = startOfFrame || reset_level;
    assign block = pause || reset_level;

    for (genvar t = 0; t < NUM_TYPES; t++) begin : g_latch
        collision_pulse_latch u_latch (
            .clk     (clk),
            .resetN  (resetN),
            .overlap (overlap_vec[t]),
            .qualify (qualify_vec[t]),
            .clear   (clear),
            .block   (block),
            .pulse   (fire_vec[t])
        );
    end

    always_comb begin
        edge_d  = edge_q;
        count_d = count_q;
        if (reset_level) begin
            count_d = '0;
        end else if (fire_vec[COL_OBSTACLE]) begin
            edge_d = edge_code;
            if (count_q != COUNT_MAX) begin
                count_d = count_q + COUNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pulse_q <= '0;
            edge_q  <= 4'b0000;
            count_q <= '0;
        end else begin
            pulse_q <= fire_vec;
            edge_q  <= edge_d;
            count_q <= count_d;
        end
    end

    assign collisionSmileyBorderTop   = pulse_q[COL_TOP];
    assign collisionSmileyBorderLeft  = pulse_q[COL_LEFT];
    assign collisionSmileyBorderRight = pulse_q[COL_RIGHT];
    assign collisionSmileyFlipper     = pulse_q[COL_FLIPPER];
    assign collisionSmileyObstacle    = pulse_q[COL_OBSTACLE];
    assign hitEdgeCode                = edge_q;
    assign obstacleHitCount           = count_q;

endmodule
